// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, instruction-class and datapath-select encodings for the multi-cycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
        S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_SYS, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] F_SYSCALL = 6'b001100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mc_instr_class.sv
// rtl/mc_instr_class.sv - combinational opcode/funct to instruction-class decode
module mc_instr_class
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] cls
);

    always_comb begin
        cls = C_ILL;
        if (op == OP_RTYPE) begin
            cls = (funct == F_SYSCALL) ? C_SYS : C_R;
        end else if (op[5:3] == 3'b001) begin
            cls = C_IALU;
        end else begin
            case (op)
                OP_LW:   cls = C_LW;
                OP_SW:   cls = C_SW;
                OP_BEQ:  cls = C_BEQ;
                OP_BNE:  cls = C_BNE;
                OP_J:    cls = C_J;
                OP_JAL:  cls = C_JAL;
                default: cls = C_ILL;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle MIPS sequencer with memory handshake and retire counter
module multi_cycle_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OP,
    input  logic [5:0]  F,
    input  logic        Zero,
    input  logic        MemAck,
    input  logic        Go,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemToReg,
    output logic        AluSrcA,
    output logic [1:0]  AluSrcB,
    output logic [1:0]  AluOpSel,
    output logic [1:0]  PCSrc,
    output logic        Halted,
    output logic        Illegal,
    output logic [31:0] InstrCount
);

    state_t       state;
    instr_class_t cls_q;
    instr_class_t dec_cls;
    logic [3:0]   dec_raw;
    logic         retire;

    mc_instr_class u_class (
        .op    (OP),
        .funct (F),
        .cls   (dec_raw)
    );

    assign dec_cls = instr_class_t'(dec_raw);

    always_comb begin
        retire = (state == S_WB_R) || (state == S_WB_I) || (state == S_WB_MEM) ||
                 (state == S_BRANCH) || (state == S_JUMP) ||
                 (state == S_MEM_WR && MemAck) ||
                 (state == S_DECODE && dec_cls == C_SYS);
    end

    // The decoded class is kept so later states can tell lw/sw, beq/bne and j/jal apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            cls_q      <= C_ILL;
            InstrCount <= '0;
        end else begin
            if (retire) InstrCount <= InstrCount + 32'd1;
            case (state)
                S_FETCH:    if (MemAck) state <= S_DECODE;
                S_DECODE: begin
                    cls_q <= dec_cls;
                    case (dec_cls)
                        C_SYS:        state <= S_HALT;
                        C_R:          state <= S_EXEC_R;
                        C_IALU:       state <= S_EXEC_I;
                        C_LW, C_SW:   state <= S_MEM_ADDR;
                        C_BEQ, C_BNE: state <= S_BRANCH;
                        C_J, C_JAL:   state <= S_JUMP;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_EXEC_R:   state <= S_WB_R;
                S_EXEC_I:   state <= S_WB_I;
                S_MEM_ADDR: state <= (cls_q == C_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (MemAck) state <= S_WB_MEM;
                S_MEM_WR:   if (MemAck) state <= S_FETCH;
                S_HALT:     if (Go) state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Outputs are forced low while rst is high so an in-flight memory request drops at once.
    always_comb begin
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = DST_RT;
        MemToReg = WB_ALUOUT;
        AluSrcA  = 1'b0;
        AluSrcB  = SRCB_RT;
        AluOpSel = ALU_ADD;
        PCSrc    = PC_ALU;
        Halted   = 1'b0;
        Illegal  = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    MemReq  = 1'b1;
                    AluSrcB = SRCB_FOUR;
                    IRWrite = MemAck;
                    PCWrite = MemAck;
                end
                S_DECODE: begin
                    AluSrcB = SRCB_IMM_SH;
                    Illegal = (dec_cls == C_ILL);
                end
                S_EXEC_R: begin
                    AluSrcA  = 1'b1;
                    AluOpSel = ALU_FUNCT;
                end
                S_EXEC_I: begin
                    AluSrcA  = 1'b1;
                    AluSrcB  = SRCB_IMM;
                    AluOpSel = ALU_FUNCT;
                end
                S_MEM_ADDR: begin
                    AluSrcA = 1'b1;
                    AluSrcB = SRCB_IMM;
                end
                S_MEM_RD: begin
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                end
                S_MEM_WR: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = DST_RD;
                end
                S_WB_I:   RegWrite = 1'b1;
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = WB_MDR;
                end
                S_BRANCH: begin
                    AluSrcA  = 1'b1;
                    AluOpSel = ALU_SUB;
                    PCSrc    = PC_ALUOUT;
                    PCWrite  = (cls_q == C_BNE) ? ~Zero : Zero;
                end
                S_JUMP: begin
                    PCSrc   = PC_JUMP;
                    PCWrite = 1'b1;
                    if (cls_q == C_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = DST_RA;
                        MemToReg = WB_PC;
                    end
                end
                S_HALT:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - scoreboard bench for the multi-cycle controller
module tb_multi_cycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  OP, F;
    logic        Zero, MemAck, Go;
    logic        MemReq, MemWrite, IorD, IRWrite, PCWrite, RegWrite;
    logic [1:0]  RegDst, MemToReg, AluSrcB, AluOpSel, PCSrc;
    logic        AluSrcA, Halted, Illegal;
    logic [31:0] InstrCount;

    typedef struct packed {
        logic       mr, mw, iord, irw, pcw, rw;
        logic [1:0] rd, m2r;
        logic       sa;
        logic [1:0] srcb, aop, pcs;
        logic       h, il;
    } ovec_t;

    typedef struct {
        ovec_t       vec;
        logic        ack, zero, go;
        logic [5:0]  op, f;
        logic [31:0] cnt;
    } ent_t;

    ent_t        sb[$];
    ent_t        e;
    ovec_t       obs_now, obs;
    logic [31:0] obs_cnt, exp_cnt;
    logic [5:0]  cur_op, cur_f;
    string       cur_test;
    int          n_checks = 0;
    int          n_fail = 0;
    int          idx;

    multi_cycle_controller dut (
        .clk(clk), .rst(rst), .OP(OP), .F(F), .Zero(Zero), .MemAck(MemAck), .Go(Go),
        .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOpSel(AluOpSel), .PCSrc(PCSrc),
        .Halted(Halted), .Illegal(Illegal), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    assign obs_now = {MemReq, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemToReg,
                      AluSrcA, AluSrcB, AluOpSel, PCSrc, Halted, Illegal};

    function automatic ovec_t e_fetch(input logic ack);
        ovec_t v = '0; v.mr = 1'b1; v.srcb = 2'b01; v.irw = ack; v.pcw = ack; return v;
    endfunction
    function automatic ovec_t e_decode(input logic ill);
        ovec_t v = '0; v.srcb = 2'b11; v.il = ill; return v;
    endfunction
    function automatic ovec_t e_exec(input logic [1:0] srcb, input logic [1:0] aop);
        ovec_t v = '0; v.sa = 1'b1; v.srcb = srcb; v.aop = aop; return v;
    endfunction
    function automatic ovec_t e_mem(input logic wr);
        ovec_t v = '0; v.mr = 1'b1; v.iord = 1'b1; v.mw = wr; return v;
    endfunction
    function automatic ovec_t e_wb(input logic [1:0] rd, input logic [1:0] m2r);
        ovec_t v = '0; v.rw = 1'b1; v.rd = rd; v.m2r = m2r; return v;
    endfunction
    function automatic ovec_t e_branch(input logic pcw);
        ovec_t v = '0; v.sa = 1'b1; v.aop = 2'b01; v.pcs = 2'b01; v.pcw = pcw; return v;
    endfunction
    function automatic ovec_t e_jump(input logic jal);
        ovec_t v = '0; v.pcs = 2'b10; v.pcw = 1'b1; v.rw = jal;
        v.rd = jal ? 2'b10 : 2'b00; v.m2r = jal ? 2'b10 : 2'b00; return v;
    endfunction
    function automatic ovec_t e_halt();
        ovec_t v = '0; v.h = 1'b1; return v;
    endfunction

    task automatic push(input ovec_t v, input logic ack, input logic zero, input logic go,
                        input logic retire);
        ent_t n;
        n.vec = v; n.ack = ack; n.zero = zero; n.go = go;
        n.op = cur_op; n.f = cur_f; n.cnt = exp_cnt;
        sb.push_back(n);
        if (retire) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic push_fetch(input int waits);
        for (int i = 0; i < waits; i++) push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_fetch(1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input ent_t s);
        OP = s.op; F = s.f; MemAck = s.ack; Zero = s.zero; Go = s.go;
        @(negedge clk);
        obs = obs_now;
        obs_cnt = InstrCount;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        @(negedge clk);
        n_checks++;
        if (obs_now !== ovec_t'(0)) begin
            n_fail++; $display("FAIL reset_outputs got %h want %h", obs_now, ovec_t'(0));
        end
        n_checks++;
        if (InstrCount !== 32'd0) begin
            n_fail++; $display("FAIL reset_count got %0d want 0", InstrCount);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_alu();
        cur_test = "alu";
        cur_op = 6'b000000; cur_f = 6'b100000;
        push_fetch(0);
        push(e_decode(1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
        push(e_exec(2'b00, 2'b10), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_wb(2'b01, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1);
        cur_op = 6'b001000; cur_f = 6'b000000;
        push_fetch(0);
        push(e_decode(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_exec(2'b10, 2'b10), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_wb(2'b00, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1);
        push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        idx = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front(); step(e); idx++;
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s[%0d] outputs got %h want %h", cur_test, idx, obs, e.vec); end
            n_checks++;
            if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] count got %0d want %0d", cur_test, idx, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_lw_wait();
        cur_test = "lw_wait";
        cur_op = 6'b100011; cur_f = 6'b000000;
        push_fetch(2);
        push(e_decode(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_exec(2'b10, 2'b00), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_mem(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_mem(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_mem(1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
        push(e_wb(2'b00, 2'b01), 1'b0, 1'b0, 1'b0, 1'b1);
        push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        idx = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front(); step(e); idx++;
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s[%0d] outputs got %h want %h", cur_test, idx, obs, e.vec); end
            n_checks++;
            if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] count got %0d want %0d", cur_test, idx, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_branch();
        cur_test = "branch";
        cur_f = 6'b000000;
        for (int k = 0; k < 4; k++) begin
            logic bne, z;
            bne = k[1]; z = k[0];
            cur_op = bne ? 6'b000101 : 6'b000100;
            push(e_fetch(1'b1), 1'b1, z, 1'b0, 1'b0);
            push(e_decode(1'b0), 1'b0, z, 1'b0, 1'b0);
            push(e_branch(z ^ bne), 1'b0, z, 1'b0, 1'b1);
        end
        push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        idx = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front(); step(e); idx++;
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s[%0d] outputs got %h want %h", cur_test, idx, obs, e.vec); end
            n_checks++;
            if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] count got %0d want %0d", cur_test, idx, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_jump();
        cur_test = "jump";
        cur_f = 6'b000000;
        for (int k = 0; k < 2; k++) begin
            cur_op = (k == 1) ? 6'b000011 : 6'b000010;
            push_fetch(0);
            push(e_decode(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
            push(e_jump(k == 1), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        idx = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front(); step(e); idx++;
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s[%0d] outputs got %h want %h", cur_test, idx, obs, e.vec); end
            n_checks++;
            if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] count got %0d want %0d", cur_test, idx, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_illegal_halt();
        cur_test = "illegal_halt";
        cur_op = 6'b111111; cur_f = 6'b000000;
        push_fetch(0);
        push(e_decode(1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
        cur_op = 6'b000000; cur_f = 6'b001100;
        push_fetch(0);
        push(e_decode(1'b0), 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) push(e_halt(), 1'b1, 1'b0, 1'b0, 1'b0);
        push(e_halt(), 1'b0, 1'b0, 1'b1, 1'b0);
        push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        idx = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front(); step(e); idx++;
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s[%0d] outputs got %h want %h", cur_test, idx, obs, e.vec); end
            n_checks++;
            if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] count got %0d want %0d", cur_test, idx, obs_cnt, e.cnt); end
        end
    endtask

    task automatic test_reset_mid_write();
        cur_test = "reset_mid_write";
        cur_op = 6'b101011; cur_f = 6'b000000;
        push_fetch(0);
        push(e_decode(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_exec(2'b10, 2'b00), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_mem(1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
        push(e_mem(1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
        idx = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front(); step(e); idx++;
            n_checks++;
            if (obs !== e.vec) begin n_fail++; $display("FAIL %s[%0d] outputs got %h want %h", cur_test, idx, obs, e.vec); end
            n_checks++;
            if (obs_cnt !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] count got %0d want %0d", cur_test, idx, obs_cnt, e.cnt); end
        end
        n_checks++;
        if (MemReq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_memreq got %b want 1", MemReq); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (MemReq !== 1'b0) begin n_fail++; $display("FAIL async_drop_memreq got %b want 0", MemReq); end
        n_checks++;
        if (InstrCount !== 32'd0) begin n_fail++; $display("FAIL async_count_clear got %0d want 0", InstrCount); end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 32'd0;
        @(negedge clk);
        n_checks++;
        if (obs_now !== e_fetch(1'b0)) begin n_fail++; $display("FAIL post_reset_fetch got %h want %h", obs_now, e_fetch(1'b0)); end
        n_checks++;
        if (InstrCount !== exp_cnt) begin n_fail++; $display("FAIL post_reset_count got %0d want %0d", InstrCount, exp_cnt); end
    endtask

    initial begin
        rst = 1'b1; OP = '0; F = '0; Zero = 1'b0; MemAck = 1'b0; Go = 1'b0;
        exp_cnt = 32'd0; cur_op = '0; cur_f = '0;
        test_reset();
        test_alu();
        test_lw_wait();
        test_branch();
        test_jump();
        test_illegal_halt();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
